sap_ram: RTL and testbench

SAP_RAM -- requirements
Module: sap_ram

---
 rtl/sap_pkg.sv | 13 +
 rtl/sap_ram_core.sv | 30 +++
 rtl/sap_ram.sv | 141 ++++++++++++++
 tb/tb_sap_ram.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP RAM: clear-FSM state encoding and default widths.
package sap_pkg;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 4;
  localparam int CLR_BASE_DEF = 8;

endpackage

// File: rtl/sap_ram_core.sv
// Storage array: one synchronous write port, two asynchronous read ports.
module sap_ram_core
  import sap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are deliberately not reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/sap_ram.sv
// SAP CPU RAM with tri-state bus port, HPS boot-loader port and an
// automatic clear of the upper region [CLR_BASE, DEPTH-1] on boot entry.
module sap_ram
  import sap_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CLR_BASE = CLR_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] data_bus,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_in,
  input  logic              mem_out,
  input  logic              bus_oe,
  input  logic              boot_load,
  input  logic              boot_we,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [DATA_W-1:0] boot_wdata,
  output logic [DATA_W-1:0] boot_rdata,
  output logic              clr_busy,
  output clr_state_e        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] CLR_FIRST = CW'(CLR_BASE);
  localparam logic [CW-1:0] CLR_LAST  = CW'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              clr_busy_q, clr_busy_d;
  logic              boot_load_q, boot_load_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [DATA_W-1:0] boot_rdata_q, boot_rdata_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] boot_rd;

  logic              cpu_en;
  logic              boot_wr;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;

  assign cpu_en   = !boot_load && !clr_busy_q;
  assign boot_wr  = boot_load && boot_we;
  assign clr_wr   = (state_q == CLR_CLEAR);
  assign clr_addr = clr_cnt_q[ADDR_W-1:0];

  // One write port: a boot write only displaces the clear when it hits the
  // same address; otherwise the clear keeps its slot.
  always_comb begin
    we    = 1'b0;
    waddr = mem_addr;
    wdata = data_bus;
    if (boot_wr && (!clr_wr || boot_addr == clr_addr)) begin
      we    = 1'b1;
      waddr = boot_addr;
      wdata = boot_wdata;
    end else if (clr_wr) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end else if (cpu_en && mem_in) begin
      we    = 1'b1;
      waddr = mem_addr;
      wdata = data_bus;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_busy_d   = clr_busy_q;
    bus_d        = bus_q;
    boot_load_d  = boot_load;
    boot_rdata_d = boot_rd;
    case (state_q)
      CLR_IDLE: begin
        if (boot_load && !boot_load_q) begin
          state_d    = CLR_CLEAR;
          clr_cnt_d  = CLR_FIRST;
          clr_busy_d = 1'b1;
          bus_d      = '0;
        end else if (cpu_en && mem_out && !mem_in) begin
          bus_d = cpu_rdata;
        end
      end
      CLR_CLEAR: begin
        // New boot_load edges are ignored here; the sequence always runs out.
        clr_cnt_d = clr_cnt_q + CW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = CLR_IDLE;
          clr_busy_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLR_IDLE;
      clr_cnt_q    <= '0;
      clr_busy_q   <= 1'b0;
      boot_load_q  <= 1'b0;
      bus_q        <= '0;
      boot_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_busy_q   <= clr_busy_d;
      boot_load_q  <= boot_load_d;
      bus_q        <= bus_d;
      boot_rdata_q <= boot_rdata_d;
    end
  end

  sap_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (mem_addr),
    .rdata_a (cpu_rdata),
    .raddr_b (boot_addr),
    .rdata_b (boot_rd)
  );

  assign data_bus   = (bus_oe && !boot_load && !clr_busy_q) ? bus_q : {DATA_W{1'bz}};
  assign boot_rdata = boot_rdata_q;
  assign clr_busy   = clr_busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sap_ram.sv
// Directed bench for sap_ram: default 8x16 instance plus a 16x32 instance.
module tb_sap_ram;
  import sap_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // Default instance (DATA_W=8, ADDR_W=4, CLR_BASE=8)
  wire  [7:0] data_bus;
  logic [7:0] bus_drv;
  logic       bus_drv_en;
  logic [3:0] mem_addr;
  logic       mem_in, mem_out, bus_oe;
  logic       boot_load, boot_we;
  logic [3:0] boot_addr;
  logic [7:0] boot_wdata;
  logic [7:0] boot_rdata;
  logic       clr_busy;
  clr_state_e dbg_state;

  // Wide instance (DATA_W=16, ADDR_W=5, CLR_BASE=24)
  wire  [15:0] w_data_bus;
  logic [15:0] w_bus_drv;
  logic        w_bus_drv_en;
  logic [4:0]  w_mem_addr;
  logic        w_mem_in, w_mem_out, w_bus_oe;
  logic        w_boot_load, w_boot_we;
  logic [4:0]  w_boot_addr;
  logic [15:0] w_boot_wdata;
  logic [15:0] w_boot_rdata;
  logic        w_clr_busy;
  clr_state_e  w_dbg_state;

  assign data_bus   = bus_drv_en   ? bus_drv   : 8'hzz;
  assign w_data_bus = w_bus_drv_en ? w_bus_drv : 16'hzzzz;

  sap_ram dut (
    .clk        (clk),
    .reset      (reset),
    .data_bus   (data_bus),
    .mem_addr   (mem_addr),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .bus_oe     (bus_oe),
    .boot_load  (boot_load),
    .boot_we    (boot_we),
    .boot_addr  (boot_addr),
    .boot_wdata (boot_wdata),
    .boot_rdata (boot_rdata),
    .clr_busy   (clr_busy),
    .dbg_state  (dbg_state)
  );

  sap_ram #(.DATA_W(16), .ADDR_W(5), .CLR_BASE(24)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .data_bus   (w_data_bus),
    .mem_addr   (w_mem_addr),
    .mem_in     (w_mem_in),
    .mem_out    (w_mem_out),
    .bus_oe     (w_bus_oe),
    .boot_load  (w_boot_load),
    .boot_we    (w_boot_we),
    .boot_addr  (w_boot_addr),
    .boot_wdata (w_boot_wdata),
    .boot_rdata (w_boot_rdata),
    .clr_busy   (w_clr_busy),
    .dbg_state  (w_dbg_state)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int          busy_n   = 0;
  int          guard;
  logic [31:0] z8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
    if (clr_busy) busy_n++;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] v);
    bus_oe     = 1'b0;
    bus_drv    = v;
    bus_drv_en = 1'b1;
    mem_addr   = a;
    mem_in     = 1'b1;
    step();
    mem_in     = 1'b0;
    bus_drv_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int a = 0; a < 16; a++) cpu_write(4'(a), v);
  endtask

  task automatic chk_mem(input string tag, input int a, input logic [7:0] e);
    boot_addr = 4'(a);
    step();
    check(tag, 32'(boot_rdata), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    z8 = {24'd0, {8{1'bz}}};
    reset = 1'b1;
    bus_drv = '0; bus_drv_en = 1'b0; mem_addr = '0; mem_in = 1'b0; mem_out = 1'b0;
    bus_oe = 1'b0; boot_load = 1'b0; boot_we = 1'b0; boot_addr = '0; boot_wdata = '0;
    w_bus_drv = '0; w_bus_drv_en = 1'b0; w_mem_addr = '0; w_mem_in = 1'b0; w_mem_out = 1'b0;
    w_bus_oe = 1'b0; w_boot_load = 1'b0; w_boot_we = 1'b0; w_boot_addr = '0; w_boot_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  32'(clr_busy), 32'd0);
    check("rst_rdata", 32'(boot_rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(CLR_IDLE));
    check("rst_bus_z", 32'(data_bus), z8);
    reset = 1'b0;
    step();

    // Bus write then read: 0xA5 at addr 3, visible one cycle after mem_out
    cpu_write(4'd3, 8'hA5);
    mem_out = 1'b1; bus_oe = 1'b1;
    step();
    check("bus_rd_a5", 32'(data_bus), 32'hA5);
    mem_out = 1'b0;
    // mem_in and mem_out together: write wins, bus_q holds
    bus_oe = 1'b0; bus_drv = 8'h3C; bus_drv_en = 1'b1; mem_addr = 4'd4;
    mem_in = 1'b1; mem_out = 1'b1;
    step();
    mem_in = 1'b0; mem_out = 1'b0; bus_drv_en = 1'b0; bus_oe = 1'b1;
    #1;
    check("both_hold", 32'(data_bus), 32'hA5);
    mem_out = 1'b1;
    step();
    check("both_wrote", 32'(data_bus), 32'h3C);
    mem_out = 1'b0; bus_oe = 1'b0;

    // Boot entry with a loader write to addr 2; clear of 8..15
    fill(8'hFF);
    busy_n = 0;
    boot_load = 1'b1; boot_we = 1'b1; boot_addr = 4'd2; boot_wdata = 8'h11;
    step();
    boot_we = 1'b0;
    check("c1_busy_on", 32'(clr_busy), 32'd1);
    bus_oe = 1'b1;
    #1;
    check("c1_bus_z_boot", 32'(data_bus), z8);
    bus_oe = 1'b0;
    guard = 0;
    while (clr_busy && guard < 40) begin
      guard++;
      step();
    end
    check("c1_busy_len", 32'(busy_n), 32'd8);
    for (int a = 8; a < 16; a++) chk_mem("c1_cleared", a, 8'h00);
    chk_mem("c1_boot_wr", 2, 8'h11);
    chk_mem("c1_low_kept", 0, 8'hFF);
    chk_mem("c1_low_kept7", 7, 8'hFF);
    boot_load = 1'b0;
    bus_oe = 1'b1;
    step();
    check("c1_bus_q_zero", 32'(data_bus), 32'h00);
    bus_oe = 1'b0;

    // Second clear: collision, non-colliding boot write, boot_load drop, re-rise, lockout
    fill(8'hFF);
    busy_n = 0;
    boot_load = 1'b1;
    step();                                   // enter CLEAR, cnt=8
    check("c2_busy_on", 32'(clr_busy), 32'd1);
    step();                                   // clears 8
    boot_we = 1'b1; boot_addr = 4'd9; boot_wdata = 8'h77;
    step();                                   // cnt=9: boot write wins
    boot_addr = 4'd3; boot_wdata = 8'h55;
    step();                                   // cnt=10: clear proceeds
    boot_we = 1'b0; boot_load = 1'b0;
    bus_drv = 8'h42; bus_drv_en = 1'b1; mem_addr = 4'd0; mem_in = 1'b1;
    step();                                   // cnt=11: CPU write locked out
    boot_load = 1'b1;
    step();                                   // cnt=12: re-rise ignored
    boot_load = 1'b0; mem_in = 1'b0; bus_drv_en = 1'b0; bus_oe = 1'b1;
    #1;
    check("c2_bus_z_busy", 32'(data_bus), z8);
    step();                                   // cnt=13
    bus_oe = 1'b0;
    step();                                   // cnt=14
    check("c2_busy_late", 32'(clr_busy), 32'd1);
    bus_drv = 8'h24; bus_drv_en = 1'b1; mem_addr = 4'd5; mem_in = 1'b1;
    step();                                   // cnt=15, last busy edge
    check("c2_busy_off", 32'(clr_busy), 32'd0);
    check("c2_busy_len", 32'(busy_n), 32'd8);
    bus_drv = 8'h25; mem_addr = 4'd1;
    step();                                   // first CPU-enabled edge
    mem_in = 1'b0; bus_drv_en = 1'b0;
    chk_mem("c2_collide", 9, 8'h77);
    chk_mem("c2_clr10", 10, 8'h00);
    chk_mem("c2_clr8", 8, 8'h00);
    chk_mem("c2_clr11", 11, 8'h00);
    chk_mem("c2_clr15", 15, 8'h00);
    chk_mem("c2_lock0", 0, 8'hFF);
    chk_mem("c2_lock5", 5, 8'hFF);
    chk_mem("c2_resume1", 1, 8'h25);

    // Reset in the middle of a clear at cnt=11
    fill(8'hFF);
    boot_load = 1'b1;
    repeat (4) step();                        // enter, then clear 8,9,10
    reset = 1'b1;
    #1;
    check("mr_busy", 32'(clr_busy), 32'd0);
    check("mr_state", 32'(dbg_state), 32'(CLR_IDLE));
    check("mr_rdata", 32'(boot_rdata), 32'd0);
    boot_load = 1'b0;
    step();
    reset = 1'b0;
    step();
    for (int a = 8; a < 11; a++) chk_mem("mr_cleared", a, 8'h00);
    for (int a = 11; a < 16; a++) chk_mem("mr_kept", a, 8'hFF);

    // Wide instance: clear of 24..31 lasts 8 cycles, 0xBEEF round-trip at 31
    w_boot_load = 1'b1;
    step();
    check("w_busy_on", 32'(w_clr_busy), 32'd1);
    guard = 0;
    while (w_clr_busy && guard < 80) begin
      guard++;
      step();
    end
    check("w_busy_len", 32'(guard), 32'd8);
    w_boot_load = 1'b0;
    w_boot_addr = 5'd24;
    step();
    check("w_clr24", 32'(w_boot_rdata), 32'd0);
    w_bus_drv = 16'hBEEF; w_bus_drv_en = 1'b1; w_mem_addr = 5'd31; w_mem_in = 1'b1;
    step();
    w_mem_in = 1'b0; w_bus_drv_en = 1'b0; w_mem_out = 1'b1; w_bus_oe = 1'b1;
    step();
    check("w_bus_beef", 32'(w_data_bus), 32'hBEEF);
    w_mem_out = 1'b0;
    w_boot_addr = 5'd31;
    step();
    check("w_rd_beef", 32'(w_boot_rdata), 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
